// File: rtl/acc_num_ctrl.sv
// -----------------------------------------------------------------------------
// acc_num_ctrl
//
// Accumulation sequencer for the correlator's vector accumulator (user clock
// domain). A rising edge on `arm` arms the block. The next `sync_in` pulse
// starts counting valid samples into vectors of VEC_LEN samples. Those vectors
// are grouped into accumulations of max(acc_len,1) vectors. The sample stream
// is re-emitted one cycle later, tagged with first/last markers that drive the
// accumulator's clear and dump.
//
// Ports
//   user_clk   in   clock, all logic on the rising edge
//   user_rst   in   synchronous active-high reset
//   arm        in   software level; a 0->1 transition is an arm request
//   sync_in    in   one-cycle sync pulse from the data source
//   valid_in   in   a sample is present this cycle
//   acc_len    in   vectors per accumulation (0 behaves as 1)
//   valid_out  out  registered copy of valid_in
//   first_out  out  tagged sample opens an accumulation (accumulator clear)
//   last_out   out  tagged sample closes an accumulation (accumulator dump)
//   acc_num    out  completed-accumulation count (software register feed)
//   state_out  out  registered FSM state: 0 IDLE, 1 ARMED, 2 RUN
//
// Stream qualification: there is no back-pressure. Every cycle with
// valid_in=1 is one sample. first_out/last_out are meaningful only in a
// cycle where valid_out=1, and are never high otherwise.
// -----------------------------------------------------------------------------
module acc_num_ctrl #(
  parameter int VEC_LEN = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             user_clk,
  input  logic             user_rst,
  input  logic             arm,
  input  logic             sync_in,
  input  logic             valid_in,
  input  logic [CNT_W-1:0] acc_len,
  output logic             valid_out,
  output logic             first_out,
  output logic             last_out,
  output logic [CNT_W-1:0] acc_num,
  output logic [1:0]       state_out
);

  localparam int CH_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CH_W-1:0] CHAN_MAX = CH_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t           r_state;
  logic [CH_W-1:0]  r_chan;
  logic [CNT_W-1:0] r_vec;
  logic [CNT_W-1:0] r_len;
  logic             r_arm_d;
  logic             r_hist_ok;
  logic             r_valid_out;
  logic             r_first_out;
  logic             r_last_out;
  logic [CNT_W-1:0] r_acc_num;

  state_t           w_state_nxt;
  logic [CH_W-1:0]  w_chan_nxt;
  logic [CNT_W-1:0] w_vec_nxt;
  logic [CNT_W-1:0] w_len_nxt;
  logic [CNT_W-1:0] w_len_load;
  logic             w_arm_edge;
  logic             w_chan_end;
  logic             w_vec_end;
  logic             w_first;
  logic             w_last;
  logic             w_acc_clr;

  // The cycle right after reset has no trustworthy history, so an arm level
  // that is already high then is not taken as an edge.
  assign w_arm_edge = arm & ~r_arm_d & r_hist_ok;
  assign w_len_load = (acc_len == '0) ? CNT_W'(1) : acc_len;
  assign w_chan_end = (r_chan == CHAN_MAX);
  assign w_vec_end  = (r_vec == (r_len - CNT_W'(1)));

  always_comb begin
    w_state_nxt = r_state;
    w_chan_nxt  = r_chan;
    w_vec_nxt   = r_vec;
    w_len_nxt   = r_len;
    w_first     = 1'b0;
    w_last      = 1'b0;
    w_acc_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arm_edge) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // A re-arm outranks a coincident sync; the sync cycle's own sample
        // is not counted.
        if (w_arm_edge) begin
          w_acc_clr = 1'b1;
        end else if (sync_in) begin
          w_state_nxt = ST_RUN;
          w_chan_nxt  = '0;
          w_vec_nxt   = '0;
          w_len_nxt   = w_len_load;
        end
      end
      ST_RUN: begin
        // An arm edge abandons the accumulation: the sample in this cycle
        // gets no marker, so a pending dump is dropped.
        if (w_arm_edge) begin
          w_state_nxt = ST_ARMED;
          w_acc_clr   = 1'b1;
        end else if (valid_in) begin
          w_first = (r_chan == '0) && (r_vec == '0);
          w_last  = w_chan_end && w_vec_end;
          if (w_last) begin
            // acc_len is only sampled at accumulation boundaries.
            w_chan_nxt = '0;
            w_vec_nxt  = '0;
            w_len_nxt  = w_len_load;
          end else if (w_chan_end) begin
            w_chan_nxt = '0;
            w_vec_nxt  = r_vec + 1'b1;
          end else begin
            w_chan_nxt = r_chan + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_state     <= ST_IDLE;
      r_chan      <= '0;
      r_vec       <= '0;
      r_len       <= '0;
      r_arm_d     <= 1'b0;
      r_hist_ok   <= 1'b0;
      r_valid_out <= 1'b0;
      r_first_out <= 1'b0;
      r_last_out  <= 1'b0;
      r_acc_num   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_chan      <= w_chan_nxt;
      r_vec       <= w_vec_nxt;
      r_len       <= w_len_nxt;
      r_arm_d     <= arm;
      r_hist_ok   <= 1'b1;
      r_valid_out <= valid_in;
      r_first_out <= w_first;
      r_last_out  <= w_last;
      // The count follows the registered dump marker, so software never sees
      // the new value before the dump cycle has started. A clear wins.
      if (w_acc_clr) begin
        r_acc_num <= '0;
      end else if (r_last_out) begin
        r_acc_num <= r_acc_num + 1'b1;
      end
    end
  end

  assign valid_out = r_valid_out;
  assign first_out = r_first_out;
  assign last_out  = r_last_out;
  assign acc_num   = r_acc_num;
  assign state_out = r_state;

endmodule

// File: doc/acc_num_ctrl.md
# acc_num_ctrl

Accumulation sequencer for the correlator's vector accumulator, running in the user clock domain. It arms from a software-register strobe, starts on the next sync pulse, and counts valid samples into vectors and vectors into accumulations. It tags the sample stream with first/last markers for the accumulator's clear and dump. It also maintains the accumulation counter that drives the `user_data_in` of the `acc_num` simulink2ppc software register.

## Interface
- `VEC_LEN`, 1024: samples per vector (channels); must be ≥ 2.
- `CNT_W`, 32: width of the `acc_len` and `acc_num` counters.
- `user_clk` in 1: the single clock; all logic is on its rising edge.
- `user_rst` in 1: synchronous, active-high reset.
- `arm` in 1: level from a ppc2simulink register; a rising edge (0→1 between consecutive cycles) is an arm request.
- `sync_in` in 1: one-cycle sync pulse from the data source.
- `valid_in` in 1: a sample is present this cycle.
- `acc_len` in CNT_W: vectors per accumulation; the value 0 is treated as 1.
- `valid_out` out 1: registered copy of `valid_in` (qualifies the markers).
- `first_out` out 1: the tagged sample is the first of an accumulation (accumulator clear).
- `last_out` out 1: the tagged sample is the last of an accumulation (accumulator dump).
- `acc_num` out CNT_W: completed-accumulation count; connects to the `acc_num` register's `user_data_in`.
- `state_out` out 2: current state code, for a status register.

## Operation
- States and encodings:
  - IDLE=0
  - ARMED=1
  - RUN=2
  - Encoding 3 is unused; if ever reached, the next state is IDLE.
- IDLE:
  - Arm edge → ARMED.
  - `sync_in` and `valid_in` are ignored; no markers are produced.
- ARMED:
  - On arm edge: `acc_num` ← 0.
  - On `sync_in`=1: → RUN with `chan_cnt`=0 and `vec_cnt`=0, and `len_q` ← max(`acc_len`,1).
  - A `valid_in` in the same cycle as `sync_in` is not counted.
- RUN (every `valid_in`=1 cycle is one sample):
  - `chan_cnt` counts 0..VEC_LEN-1 and then wraps to 0.
  - On the wrap, `vec_cnt` increments.
  - The sample with `chan_cnt`=0 and `vec_cnt`=0 is marked first.
  - The sample with `chan_cnt`=VEC_LEN-1 and `vec_cnt`=len_q-1 is marked last.
  - After the last sample, both counters return to 0 and `len_q` reloads from `acc_len`. A change to `acc_len` therefore takes effect only at an accumulation boundary.
  - `acc_num` increments by 1 (modulo 2^CNT_W) once per last sample.
  - `sync_in` is ignored while in RUN.
- Arm edge while in RUN:
  - Abandon the current accumulation: no `last_out` is produced and `acc_num` does not increment.
  - → ARMED; `acc_num` ← 0.
- When `len_q`=1, every vector is a full accumulation: `first_out` at `chan_cnt`=0 and `last_out` at VEC_LEN-1.
- Simultaneous events:
  - Arm edge and `sync_in` in the same cycle while in ARMED: the arm edge wins (stay in ARMED, clear `acc_num`, sync ignored).
  - Arm edge and the last sample in the same cycle while in RUN: the arm edge wins (no `last_out`, no increment).
- Counter widths: `chan_cnt` is clog2(VEC_LEN) bits; `vec_cnt` is CNT_W bits.

## Timing
- Reset values:
  - State = IDLE.
  - `valid_out`, `first_out`, `last_out` = 0.
  - `acc_num` = 0; `state_out` = 0.
  - Counters = 0; arm edge detector history = 0.
  - An arm level that is still high after reset is not an edge; software must pulse it.
- Markers:
  - A `valid_in` at cycle t produces `valid_out`/`first_out`/`last_out` at t+1.
  - `first_out` and `last_out` are only ever high together with `valid_out`.
- `acc_num` changes at t+2 for a last sample at t, i.e. one cycle after `last_out`. A software read never sees the new count before the dump has started.
- `state_out` reflects the registered state, so it changes one cycle after the triggering input.
- Gaps in `valid_in` stall the counters only and are never an error.
- Reset asserted mid-accumulation: the next cycle is the full reset state, with no `last_out` emitted.

## Test plan
- Reset with `arm` held at 1, then toggle inputs → `state_out` stays 0, no markers, `acc_num`=0.
- VEC_LEN=4, `acc_len`=2:
  - Stimulus: arm pulse, `sync_in` at cycle 10, continuous `valid_in`.
  - Required: `first_out` at cycles 12, 20, 28; `last_out` at 19, 27; `acc_num` = 1 at cycle 20 and 2 at cycle 28.
- Same setup with `valid_in` toggling every other cycle → markers stretch to one per 16 cycles; 8 valid samples per accumulation; counts identical.
- `acc_len` changed from 2 to 0 mid-accumulation → current accumulation ends after 8 samples; subsequent accumulations are 4 samples each.
- Arm edge on the cycle of the 5th sample of an accumulation:
  - No `last_out`; `acc_num`=0; `state_out`=1.
  - The next `sync_in` restarts with `first_out` on the following valid sample.
- Preload `acc_num` to 2^32-1 via forced state, then complete one accumulation → `acc_num` wraps to 0.
